// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one 32-bit shift datapath between requesters A and B.
// Round-robin arbitration, one registered result stage with valid/ready
// backpressure. Optional grant counters are enabled by the macro
// SHIFT_ARBITER_STATS_EN (adds CNT_W parameter and a_grants/b_grants outputs).

module shift_left_logical #(
    parameter int N = 32
) (
    input  logic [N-1:0] in_data,
    input  logic [4:0]   shamt,
    output logic [N-1:0] out_data
);
    assign out_data = in_data << shamt;
endmodule

module shift_right_logical #(
    parameter int N = 32
) (
    input  logic [N-1:0] in_data,
    input  logic [4:0]   shamt,
    output logic [N-1:0] out_data
);
    assign out_data = in_data >> shamt;
endmodule

module shift_right_arithmetic #(
    parameter int N = 32
) (
    input  logic [N-1:0] in_data,
    input  logic [4:0]   shamt,
    output logic [N-1:0] out_data
);
    assign out_data = $signed(in_data) >>> shamt;
endmodule

module shift_arbiter #(
    parameter int N = 32
`ifdef SHIFT_ARBITER_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [N-1:0] a_data,
    input  logic [4:0]   a_shamt,
    input  logic [1:0]   a_op,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [N-1:0] b_data,
    input  logic [4:0]   b_shamt,
    input  logic [1:0]   b_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_src
`ifdef SHIFT_ARBITER_STATS_EN
    ,
    output logic [CNT_W-1:0] a_grants,
    output logic [CNT_W-1:0] b_grants
`endif
);

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    logic         rsp_valid_q, rsp_valid_d;
    logic [N-1:0] rsp_data_q,  rsp_data_d;
    logic         rsp_src_q,   rsp_src_d;
    logic         last_grant_q, last_grant_d;

    logic         avail;
    logic         grant_a, grant_b;
    logic         accept;
    logic         winner;
    logic [N-1:0] sel_data;
    logic [4:0]   sel_shamt;
    logic [1:0]   sel_op;
    logic [N-1:0] sll_out, srl_out, sra_out;
    logic [N-1:0] result;

    // Arbitration: the stage is free when empty or being drained; ties go to
    // whoever was not granted last.
    always_comb begin
        avail   = !rsp_valid_q || rsp_ready;
        grant_a = a_valid && (!b_valid || last_grant_q);
        grant_b = b_valid && (!a_valid || !last_grant_q);
        a_ready = avail && grant_a;
        b_ready = avail && grant_b;
        accept  = a_ready || b_ready;
        winner  = b_ready;
    end

    // Operand mux: steer the winning requester's operation into the datapath.
    always_comb begin
        sel_data  = winner ? b_data  : a_data;
        sel_shamt = winner ? b_shamt : a_shamt;
        sel_op    = winner ? b_op    : a_op;
    end

    shift_left_logical #(.N(N)) u_sll (
        .in_data (sel_data),
        .shamt   (sel_shamt),
        .out_data(sll_out)
    );

    shift_right_logical #(.N(N)) u_srl (
        .in_data (sel_data),
        .shamt   (sel_shamt),
        .out_data(srl_out)
    );

    shift_right_arithmetic #(.N(N)) u_sra (
        .in_data (sel_data),
        .shamt   (sel_shamt),
        .out_data(sra_out)
    );

    // Result select by opcode; PASS bypasses the shifters entirely.
    always_comb begin
        result = sel_data;
        case (op_e'(sel_op))
            OP_SLL:  result = sll_out;
            OP_SRL:  result = srl_out;
            OP_SRA:  result = sra_out;
            OP_PASS: result = sel_data;
            default: result = sel_data;
        endcase
    end

    // Next state of the result stage: load on accept, empty on a bare pop,
    // otherwise hold (covers backpressure).
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_src_d    = rsp_src_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = result;
            rsp_src_d    = winner;
            last_grant_d = winner;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Result stage and round-robin pointer; reset makes A win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_src_q    <= rsp_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_src   = rsp_src_q;

`ifdef SHIFT_ARBITER_STATS_EN
    logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

    // Saturating grant counters, bumped on each requester's accept.
    always_comb begin
        a_cnt_d = a_cnt_q;
        b_cnt_d = b_cnt_q;
        if (a_ready && (a_cnt_q != '1)) begin
            a_cnt_d = a_cnt_q + 1'b1;
        end
        if (b_ready && (b_cnt_q != '1)) begin
            b_cnt_d = b_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt_q <= '0;
            b_cnt_q <= '0;
        end else begin
            a_cnt_q <= a_cnt_d;
            b_cnt_q <= b_cnt_d;
        end
    end

    assign a_grants = a_cnt_q;
    assign b_grants = b_cnt_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter. Expected results are queued when an
// accept is expected and compared while they sit in the result register.
// The stats section is built only when SHIFT_ARBITER_STATS_EN is defined.

module tb_shift_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid, a_ready;
    logic [31:0] a_data;
    logic [4:0]  a_shamt;
    logic [1:0]  a_op;
    logic        b_valid, b_ready;
    logic [31:0] b_data;
    logic [4:0]  b_shamt;
    logic [1:0]  b_op;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_src;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];
    logic        model_valid;

`ifdef SHIFT_ARBITER_STATS_EN
    logic [1:0] a_grants, b_grants;

    shift_arbiter #(.N(32), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .a_shamt(a_shamt), .a_op(a_op),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .b_shamt(b_shamt), .b_op(b_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_src(rsp_src),
        .a_grants(a_grants), .b_grants(b_grants)
    );
`else
    shift_arbiter #(.N(32)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .a_shamt(a_shamt), .a_op(a_op),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .b_shamt(b_shamt), .b_op(b_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_src(rsp_src)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference shifter written with masks rather than shift operators on signed data.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] sh,
                                              input logic [1:0] op);
        logic [31:0] r;
        case (op)
            2'b00:   r = d << sh;
            2'b01:   r = d >> sh;
            2'b10:   r = (d >> sh) | (d[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [31:0] ad, input logic [4:0] ash,
                                 input logic [1:0] aop, input logic bv, input logic [31:0] bd,
                                 input logic [4:0] bsh, input logic [1:0] bop, input logic rr);
        a_valid = av; a_data = ad; a_shamt = ash; a_op = aop;
        b_valid = bv; b_data = bd; b_shamt = bsh; b_op = bop;
        rsp_ready = rr;
    endtask

    // One cycle: check readies and the held result at the falling edge, then
    // advance past the rising edge and update the model of the result stage.
    task automatic checkOutput(input string tag, input logic exp_ar, input logic exp_br,
                               input logic [31:0] exp_res);
        logic [32:0] front;
        @(negedge clk);
        chk({tag, ".a_ready"}, {31'b0, a_ready}, {31'b0, exp_ar});
        chk({tag, ".b_ready"}, {31'b0, b_ready}, {31'b0, exp_br});
        chk({tag, ".rsp_valid"}, {31'b0, rsp_valid}, {31'b0, model_valid});
        if (model_valid && exp_q.size() > 0) begin
            front = exp_q[0];
            chk({tag, ".rsp_data"}, rsp_data, front[31:0]);
            chk({tag, ".rsp_src"}, {31'b0, rsp_src}, {31'b0, front[32]});
            if (rsp_ready) void'(exp_q.pop_front());
        end
        if (exp_ar || exp_br) exp_q.push_back({exp_br, exp_res});
        @(posedge clk);
        #1;
        if (exp_ar || exp_br) model_valid = 1'b1;
        else if (rsp_ready) model_valid = 1'b0;
    endtask

    initial begin
        logic        exp_b;
        logic [31:0] ra, rb;
        logic [4:0]  sa, sb;
        logic [1:0]  oa, ob;

        model_valid = 1'b0;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("reset.rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("reset.rsp_data", rsp_data, 32'h0);
        chk("reset.rsp_src", {31'b0, rsp_src}, 32'h0);
        chk("reset.a_ready", {31'b0, a_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // A alone, SRA of 0x80000001 by 1.
        applyStimulus(1, 32'h8000_0001, 1, 2'b10, 0, 0, 0, 0, 1);
        checkOutput("a_only", 1, 0, 32'hC000_0000);
        // B alone, SRL boundary at shamt 31; also pops the A result.
        applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 31, 2'b01, 1);
        checkOutput("b_srl31", 0, 1, 32'h0000_0001);

        // Both valid for four cycles: A, B, A, B with back-to-back results.
        applyStimulus(1, 32'hFFFF_FFFF, 31, 2'b00, 1, 32'h0000_000F, 4, 2'b00, 1);
        checkOutput("rr0_sll31", 1, 0, 32'h8000_0000);
        checkOutput("rr1_b_sll4", 0, 1, 32'h0000_00F0);
        applyStimulus(1, 32'h1234_5678, 7, 2'b11, 1, 32'h0000_000F, 4, 2'b00, 1);
        checkOutput("rr2_pass", 1, 0, 32'h1234_5678);
        checkOutput("rr3_b_sll4", 0, 1, 32'h0000_00F0);

        // Backpressure for three cycles with both requesters waiting.
        applyStimulus(1, 32'h8000_0000, 0, 2'b10, 1, 32'h0000_0003, 2, 2'b01, 0);
        checkOutput("bp0", 0, 0, 32'h0);
        checkOutput("bp1", 0, 0, 32'h0);
        checkOutput("bp2", 0, 0, 32'h0);
        // Release: pop and accept A (SRA by 0) in the same cycle.
        rsp_ready = 1'b1;
        checkOutput("bp_release", 1, 0, 32'h8000_0000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("drain", 0, 0, 32'h0);
        checkOutput("idle", 0, 0, 32'h0);

        // Random operations with both valid; grants alternate starting at B.
        exp_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            sa = 5'($urandom_range(0, 31)); sb = 5'($urandom_range(0, 31));
            oa = 2'($urandom_range(0, 3));  ob = 2'($urandom_range(0, 3));
            applyStimulus(1, ra, sa, oa, 1, rb, sb, ob, 1);
            checkOutput("rand", !exp_b, exp_b, exp_b ? ref_shift(rb, sb, ob) : ref_shift(ra, sa, oa));
            exp_b = !exp_b;
        end

        // Reset while a result is held and both requesters are pending.
        applyStimulus(1, 32'h0000_00FF, 4, 2'b00, 0, 0, 0, 0, 1);
        checkOutput("pre_rst", 1, 0, 32'h0000_0FF0);
        applyStimulus(1, 32'h0000_0001, 1, 2'b00, 1, 32'h0000_0002, 1, 2'b00, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("async_rst.rsp_data", rsp_data, 32'h0);
        exp_q.delete();
        model_valid = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1, 32'h0000_0001, 1, 2'b00, 1, 32'h0000_0002, 1, 2'b00, 1);
        checkOutput("post_rst_a_first", 1, 0, 32'h0000_0002);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("post_rst_drain", 0, 0, 32'h0);

`ifdef SHIFT_ARBITER_STATS_EN
        rst = 1'b1;
        #2;
        rst = 1'b0;
        exp_q.delete();
        model_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stats.clear", {30'b0, a_grants}, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 32'h0000_0010, 1, 2'b01, 0, 0, 0, 0, 1);
            checkOutput("stats_a", 1, 0, 32'h0000_0008);
            chk("stats.a_grants", {30'b0, a_grants}, (i > 3) ? 32'd3 : 32'(i));
            chk("stats.b_grants", {30'b0, b_grants}, 32'h0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit shift datapath between two requesters, A and B. The datapath provides logical-left, logical-right and arithmetic-right shifts, built from the team's shift_left_logical, shift_right_logical and shift_right_arithmetic blocks.
- Each requester uses a valid/ready handshake. Arbitration is round-robin.
- There is one registered result stage with valid/ready backpressure toward the consumer.
- Sits between the ALU issue logic and a secondary shift-heavy client, such as the bit-serial peripheral engine.

Parameters:
- N, 32, datapath width. Only 32 is supported.
- CNT_W, 16, width of the grant counters. Used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A has an operation
- a_ready  out  1  A's operation is accepted this cycle
- a_data  in  N  A operand
- a_shamt  in  5  A shift amount
- a_op  in  2  A opcode: 00 SLL, 01 SRL, 10 SRA, 11 PASS
- b_valid  in  1  requester B has an operation
- b_ready  out  1  B's operation is accepted this cycle
- b_data  in  N  B operand
- b_shamt  in  5  B shift amount
- b_op  in  2  B opcode, same encoding as a_op
- rsp_valid  out  1  result register holds a result
- rsp_ready  in  1  consumer takes the result
- rsp_data  out  N  shifted result
- rsp_src  out  1  result owner: 0 = A, 1 = B

Behaviour:
- Reset (asynchronous, active-high): rsp_valid=0, rsp_data=0, rsp_src=0, last_grant=1, so A wins the first tie. Counters reset to 0.
- Stage availability: avail = !rsp_valid || rsp_ready.
- Grant rules:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - No grant when avail=0.
- Ready outputs: a_ready = avail && grant_a; b_ready = avail && grant_b.
  - Readies are combinational from valids, rsp_valid and rsp_ready.
  - At most one ready is asserted per cycle.
  - A ready is never asserted while its own valid is low.
- Accept: the granted requester's op is selected and the shift result is computed combinationally. On the edge:
  - rsp_data <= result
  - rsp_src <= winner
  - rsp_valid <= 1
  - last_grant <= winner
- Latency: accept at edge t, result visible with rsp_valid=1 after edge t.
- Throughput: one op per cycle. A result popped (rsp_ready=1) in a cycle in which a new op is accepted is replaced at the same edge, with no bubble.
- Pop without accept: rsp_valid <= 0. rsp_data holds its last value.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data and rsp_src are stable and both readies are 0. last_grant is unchanged.
- Opcode semantics:
  - SLL = in << shamt, zero fill.
  - SRL = in >> shamt, zero fill.
  - SRA fills with in[31].
  - PASS returns in unchanged, ignoring shamt.
  - shamt=0 returns in for every op.
- Requester inputs are sampled only on the accept edge. Valid may drop without a handshake; there is no stickiness requirement.
- Reset mid-operation: the pending result is discarded and rsp_valid clears immediately (asynchronous). Arbitration restarts with A preferred.

Optional Feature:
- Macro SHIFT_ARBITER_STATS_EN.
- Defined:
  - Adds outputs a_grants and b_grants, each CNT_W wide.
  - Each increments on its requester's accept edge.
  - Saturates at all-ones; no wrap.
  - Cleared by rst.
- Not defined: ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, then A only: a_data=0x80000001, a_shamt=1, a_op=SRA.
  - Required: a_ready=1 that cycle.
  - Next cycle: rsp_valid=1, rsp_data=0xC0000000, rsp_src=0.
- Both valid continuously for 4 cycles with rsp_ready=1:
  - Grants go A, B, A, B.
  - B with b_data=0x0000000F, b_shamt=4, b_op=SLL yields 0x000000F0.
  - Results arrive back-to-back with no bubble.
- Backpressure: hold rsp_ready=0 for 3 cycles after a result.
  - Required: a_ready=b_ready=0; rsp_data and rsp_src unchanged.
  - Raise rsp_ready: the next op is accepted in the same cycle as the pop.
- Boundaries:
  - shamt=31, SRL on 0xFFFFFFFF gives 0x00000001.
  - shamt=31, SLL on 0xFFFFFFFF gives 0x80000000.
  - PASS with shamt=7 on 0x12345678 gives 0x12345678.
  - shamt=0, SRA on 0x80000000 gives 0x80000000.
- Assert rst while rsp_valid=1 and a request is pending.
  - Required: rsp_valid=0 immediately, without waiting for an edge.
  - After release, with both valid: A is granted first.
- With SHIFT_ARBITER_STATS_EN and CNT_W=2: 5 accepts from A.
  - Required: a_grants saturates at 3; b_grants=0.
